// File: rtl/ndp_nack_coalescer_pkg.sv
// ndp_nack_coalescer_pkg
//   Shared packet-type encodings, sequence/window widths and helpers for the
//   NDP NACK coalescer and its range FIFO.
//   Contents:
//     pkt_type_e / NACK_PKT   packet type encoding seen from the parser
//     FLOW_SEQ_NUM_W          sequence number width (wraps mod 2^W)
//     FLOW_WIN_SIZE_W         window size width
//     nack_act_e              what an accepted NACK does to its flow slot
//     clogb2()                flow-id width from flow count (minimum 1)
//     rtx_range_w()           FIFO entry width {flow, start, end}
package ndp_nack_coalescer_pkg;

   localparam int PKT_TYPE_W      = 2;
   localparam int FLOW_SEQ_NUM_W  = 16;
   localparam int FLOW_WIN_SIZE_W = 16;

   typedef enum logic [PKT_TYPE_W-1:0] {
      PKT_DATA = 2'd0,
      PKT_ACK  = 2'd1,
      PKT_NACK = 2'd2,
      PKT_PULL = 2'd3
   } pkt_type_e;

   localparam logic [PKT_TYPE_W-1:0] NACK_PKT = PKT_NACK;

   typedef enum logic [1:0] {
      ACT_OPEN   = 2'd0,  // slot empty: start a new one-seq range
      ACT_EXTEND = 2'd1,  // seq == end: grow the range by one
      ACT_DUP    = 2'd2,  // seq already inside the range: absorb
      ACT_SPLIT  = 2'd3   // seq elsewhere: emit old range, open a new one
   } nack_act_e;

   function automatic int clogb2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int rtx_range_w(input int flow_id_w);
      return flow_id_w + 2 * FLOW_SEQ_NUM_W;
   endfunction

endpackage

// File: rtl/ndp_rtx_fifo.sv
// ndp_rtx_fifo
//   Synchronous FIFO with registered storage: rd_data comes straight from the
//   storage array, so a word written at one edge is visible after that edge and
//   never combinationally from wr_data. A write while full is accepted only
//   when a read happens in the same cycle.
//   Ports:
//     clk, rst_n       clock, synchronous active-low reset
//     wr_en, wr_data   push request and word
//     rd_en            pop request (ignored when empty)
//     rd_data          head word (valid when ~empty)
//     full, empty      status
//     count            number of stored words
module ndp_rtx_fifo import ndp_nack_coalescer_pkg::*; #(
   parameter int W     = 34,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          wr_ok, rd_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign rd_ok = rd_en & ~empty;
   assign wr_ok = wr_en & (~full | rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: count_q gates what is visible.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/ndp_nack_coalescer.sv
// ndp_nack_coalescer
//   Multi-flow NDP retransmit front-end. Per-packet NACKs are coalesced into
//   [start,end) ranges, one pending range per flow, flushed into an output FIFO
//   when the range reaches MAX_RANGE, when a non-adjacent NACK arrives, or when
//   the range has been idle for HOLD_CYCLES.
//   Handshakes: an input event transfers on a cycle where in_valid & in_ready;
//   an output range transfers on a cycle where out_valid & out_ready. Neither
//   valid depends combinationally on its own ready.
//   Ports:
//     in_*            packet event (only NACK_PKT acted on), in_ready = ~fifo full
//     clr_valid/id    discard a flow's pending range without output
//     out_*           coalesced range {flow, start, exclusive end}
//     drop_cnt        saturating count of dropped NACKs
module ndp_nack_coalescer import ndp_nack_coalescer_pkg::*; #(
   parameter int NUM_FLOWS   = 4,
   parameter int FLOW_ID_W   = clogb2(NUM_FLOWS),
   parameter int HOLD_CYCLES = 16,
   parameter int MAX_RANGE   = 8,
   parameter int FIFO_DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PKT_TYPE_W-1:0]      in_pkt_type,
   input  logic [FLOW_ID_W-1:0]       in_flow_id,
   input  logic [FLOW_SEQ_NUM_W-1:0]  in_seq,
   input  logic [FLOW_SEQ_NUM_W-1:0]  in_wnd_start,
   input  logic [FLOW_WIN_SIZE_W-1:0] in_wnd_size,
   input  logic                       clr_valid,
   input  logic [FLOW_ID_W-1:0]       clr_flow_id,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FLOW_ID_W-1:0]       out_flow_id,
   output logic [FLOW_SEQ_NUM_W-1:0]  out_rtx_start,
   output logic [FLOW_SEQ_NUM_W-1:0]  out_rtx_end,
   output logic [15:0]                drop_cnt
);

   localparam int SW    = FLOW_SEQ_NUM_W;
   localparam int RW    = rtx_range_w(FLOW_ID_W);
   localparam int AGE_W = $clog2(HOLD_CYCLES + 1);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_FLOWS-1:0] occ_q, occ_d;
   logic [SW-1:0]        start_q [NUM_FLOWS];
   logic [SW-1:0]        start_d [NUM_FLOWS];
   logic [SW-1:0]        end_q   [NUM_FLOWS];
   logic [SW-1:0]        end_d   [NUM_FLOWS];
   logic [AGE_W-1:0]     age_q   [NUM_FLOWS];
   logic [AGE_W-1:0]     age_d   [NUM_FLOWS];
   logic [15:0]          drop_cnt_q, drop_cnt_d;

   logic                 fifo_full, fifo_empty, fifo_rd, fifo_wr, fifo_can_wr;
   logic [CW-1:0]        fifo_count;
   logic [RW-1:0]        fifo_wdata, fifo_rdata;

   logic                 in_win, flow_ok, nack_fire, clr_hit, take, drop;
   logic [SW-1:0]        seq_off;
   logic                 sel_occ;
   logic [SW-1:0]        sel_start, sel_end, sel_end_nxt;
   nack_act_e            act;
   logic                 nack_wr, to_any, to_wr;
   logic [RW-1:0]        nack_data, to_data;
   logic [FLOW_ID_W-1:0] to_idx;
   logic [NUM_FLOWS-1:0] elig;

   assign in_ready    = ~fifo_full;
   assign out_valid   = ~fifo_empty;
   assign fifo_rd     = out_valid & out_ready;
   // A pop in the same cycle frees the slot a full FIFO needs for a write.
   assign fifo_can_wr = (fifo_count != CW'(FIFO_DEPTH)) | fifo_rd;
   assign {out_flow_id, out_rtx_start, out_rtx_end} = out_valid ? fifo_rdata : '0;
   assign drop_cnt    = drop_cnt_q;

   // Wrap-safe window test: distance from window start, modulo 2^SW.
   assign seq_off   = in_seq - in_wnd_start;
   assign in_win    = 32'(seq_off) < 32'(in_wnd_size);
   assign flow_ok   = 32'(in_flow_id) < NUM_FLOWS;
   assign nack_fire = in_valid & in_ready & (in_pkt_type == NACK_PKT);
   assign clr_hit   = clr_valid & (clr_flow_id == in_flow_id);
   assign take      = nack_fire & in_win & flow_ok & ~clr_hit;
   assign drop      = nack_fire & ~take;

   always_comb begin
      sel_occ   = 1'b0;
      sel_start = '0;
      sel_end   = '0;
      for (int i = 0; i < NUM_FLOWS; i++) begin
         if (FLOW_ID_W'(i) == in_flow_id) begin
            sel_occ   = occ_q[i];
            sel_start = start_q[i];
            sel_end   = end_q[i];
         end
      end
      sel_end_nxt = sel_end + SW'(1);
      if (!sel_occ)                                      act = ACT_OPEN;
      else if (in_seq == sel_end)                        act = ACT_EXTEND;
      else if ((in_seq - sel_start) < (sel_end - sel_start)) act = ACT_DUP;
      else                                               act = ACT_SPLIT;
   end

   always_comb begin
      occ_d      = occ_q;
      start_d    = start_q;
      end_d      = end_q;
      nack_wr    = 1'b0;
      nack_data  = '0;
      to_any     = 1'b0;
      to_idx     = '0;
      to_data    = '0;
      drop_cnt_d = drop_cnt_q;

      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

      // NACK-triggered emissions: range reached MAX_RANGE, or a split.
      if (take && act == ACT_EXTEND && (sel_end_nxt - sel_start) == SW'(MAX_RANGE)) begin
         nack_wr   = 1'b1;
         nack_data = {in_flow_id, sel_start, sel_end_nxt};
      end else if (take && act == ACT_SPLIT) begin
         nack_wr   = 1'b1;
         nack_data = {in_flow_id, sel_start, sel_end};
      end

      // A slot being cleared or touched by this cycle's NACK is not a timeout
      // candidate this cycle. Scanning downward leaves the lowest index selected.
      for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
         elig[i] = occ_q[i] && (age_q[i] >= AGE_W'(HOLD_CYCLES))
                   && !(clr_valid && clr_flow_id == FLOW_ID_W'(i))
                   && !(take && in_flow_id == FLOW_ID_W'(i));
         if (elig[i]) begin
            to_any  = 1'b1;
            to_idx  = FLOW_ID_W'(i);
            to_data = {FLOW_ID_W'(i), start_q[i], end_q[i]};
         end
      end
      to_wr = to_any & ~nack_wr & fifo_can_wr;

      for (int i = 0; i < NUM_FLOWS; i++) begin
         age_d[i] = !occ_q[i] ? '0 :
                    (age_q[i] == AGE_W'(HOLD_CYCLES)) ? age_q[i] : age_q[i] + AGE_W'(1);
         if (clr_valid && clr_flow_id == FLOW_ID_W'(i)) begin
            occ_d[i] = 1'b0;
            age_d[i] = '0;
         end else if (take && in_flow_id == FLOW_ID_W'(i)) begin
            case (act)
               ACT_OPEN, ACT_SPLIT: begin
                  occ_d[i]   = 1'b1;
                  start_d[i] = in_seq;
                  end_d[i]   = in_seq + SW'(1);
                  age_d[i]   = '0;
               end
               ACT_EXTEND: begin
                  age_d[i] = '0;
                  if (nack_wr) occ_d[i] = 1'b0;
                  else         end_d[i] = sel_end_nxt;
               end
               default: ; // duplicate: range and age continue untouched
            endcase
         end else if (to_wr && to_idx == FLOW_ID_W'(i)) begin
            occ_d[i] = 1'b0;
            age_d[i] = '0;
         end
      end

      fifo_wr    = nack_wr | to_wr;
      fifo_wdata = nack_wr ? nack_data : to_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q      <= '0;
         drop_cnt_q <= '0;
         for (int i = 0; i < NUM_FLOWS; i++) begin
            start_q[i] <= '0;
            end_q[i]   <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         occ_q      <= occ_d;
         drop_cnt_q <= drop_cnt_d;
         for (int i = 0; i < NUM_FLOWS; i++) begin
            start_q[i] <= start_d[i];
            end_q[i]   <= end_d[i];
            age_q[i]   <= age_d[i];
         end
      end
   end

   ndp_rtx_fifo #(.W(RW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_ndp_nack_coalescer.sv
module tb_ndp_nack_coalescer;
   import ndp_nack_coalescer_pkg::*;

   localparam int FW   = 2;
   localparam int SW   = 16;
   localparam int RW   = FW + 2 * SW;
   localparam int HOLD = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready;
   logic [1:0]      in_pkt_type;
   logic [FW-1:0]   in_flow_id;
   logic [SW-1:0]   in_seq, in_wnd_start;
   logic [15:0]     in_wnd_size;
   logic            clr_valid;
   logic [FW-1:0]   clr_flow_id;
   logic            out_valid, out_ready;
   logic [FW-1:0]   out_flow_id;
   logic [SW-1:0]   out_rtx_start, out_rtx_end;
   logic [15:0]     drop_cnt;

   int              checks = 0;
   int              errors = 0;
   logic [RW-1:0]   exp_q[$];
   logic [RW-1:0]   mon_exp;

   ndp_nack_coalescer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_pkt_type   (in_pkt_type),
      .in_flow_id    (in_flow_id),
      .in_seq        (in_seq),
      .in_wnd_start  (in_wnd_start),
      .in_wnd_size   (in_wnd_size),
      .clr_valid     (clr_valid),
      .clr_flow_id   (clr_flow_id),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_flow_id   (out_flow_id),
      .out_rtx_start (out_rtx_start),
      .out_rtx_end   (out_rtx_end),
      .drop_cnt      (drop_cnt)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] rng(input int f, input int s, input int e);
      return {FW'(f), SW'(s), SW'(e)};
   endfunction

   // driver tasks: inputs change 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic send(input int f, input int seq, input int ws, input int wsz);
      int guard;
      guard = 0;
      while (!in_ready && guard < 200) begin
         step();
         guard++;
      end
      if (!in_ready) check("send_in_ready_wait", 64'(in_ready), 64'd1);
      in_valid     = 1'b1;
      in_pkt_type  = NACK_PKT;
      in_flow_id   = FW'(f);
      in_seq       = SW'(seq);
      in_wnd_start = SW'(ws);
      in_wnd_size  = 16'(wsz);
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         step();
         guard++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d ranges still outstanding after 200 cycles, expected 0", name, exp_q.size());
      end
   endtask

   // scoreboard monitor: compares every popped range against the expected queue
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_range: got 0x%0h, expected no output",
                        {out_flow_id, out_rtx_start, out_rtx_end});
            end else begin
               mon_exp = exp_q.pop_front();
               check("range", 64'({out_flow_id, out_rtx_start, out_rtx_end}), 64'(mon_exp));
            end
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_pkt_type  = PKT_DATA;
      in_flow_id   = '0;
      in_seq       = '0;
      in_wnd_start = '0;
      in_wnd_size  = '0;
      clr_valid    = 1'b0;
      clr_flow_id  = '0;
      out_ready    = 1'b1;
      idle(3);
      rst_n = 1'b1;
      step();

      // reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
      check("rst_out_data",  64'({out_flow_id, out_rtx_start, out_rtx_end}), 64'd0);

      // consecutive NACKs coalesce; idle flush lands HOLD+1 edges after the last one
      send(0, 100, 90, 64);
      send(0, 101, 90, 64);
      send(0, 102, 90, 64);
      exp_q.push_back(rng(0, 100, 103));
      idle(HOLD);
      check("hold_not_yet", 64'(out_valid), 64'd0);
      step();
      check("hold_flush_visible", 64'(out_valid), 64'd1);
      wait_drain("t1_drain");

      // eight back-to-back NACKs hit MAX_RANGE and flush on the 8th edge
      for (int s = 10; s < 18; s++) send(1, s, 0, 64);
      exp_q.push_back(rng(1, 10, 18));
      check("max_range_immediate", 64'(out_valid), 64'd1);
      wait_drain("t2_drain");

      // non-adjacent NACK splits; the later range flushes after the hold
      send(2, 5, 0, 64);
      send(2, 9, 0, 64);
      exp_q.push_back(rng(2, 5, 6));
      exp_q.push_back(rng(2, 9, 10));
      check("split_immediate", 64'(out_valid), 64'd1);
      wait_drain("t3_drain_a");
      send(2, 5, 0, 64);
      exp_q.push_back(rng(2, 5, 6));
      wait_drain("t3_drain_b");

      // sequence wrap across 0xFFFF, then an out-of-window NACK is dropped
      send(3, 'hFFFF, 'hFFFE, 8);
      send(3, 'h0000, 'hFFFE, 8);
      send(3, 'h0001, 'hFFFE, 8);
      send(3, 'h0010, 'hFFFE, 8);
      exp_q.push_back(rng(3, 'hFFFF, 'h0002));
      check("wrap_drop_cnt", 64'(drop_cnt), 64'd1);
      wait_drain("t4_drain");

      // FIFO fills with the consumer stalled; pending timeouts drain lowest index first
      out_ready = 1'b0;
      send(3, 70, 0, 256);
      send(2, 60, 0, 256);
      send(1, 50, 0, 256);
      for (int k = 0; k < 9; k++) send(0, 200 + 2 * k, 0, 256);
      for (int k = 0; k < 8; k++) exp_q.push_back(rng(0, 200 + 2 * k, 201 + 2 * k));
      exp_q.push_back(rng(0, 216, 217));
      exp_q.push_back(rng(1, 50, 51));
      exp_q.push_back(rng(2, 60, 61));
      exp_q.push_back(rng(3, 70, 71));
      check("full_in_ready_low", 64'(in_ready), 64'd0);
      idle(30);
      check("full_held_in_ready", 64'(in_ready), 64'd0);
      check("full_head_start", 64'(out_rtx_start), 64'd200);
      out_ready = 1'b1;
      wait_drain("t5_drain");
      check("drained_in_ready", 64'(in_ready), 64'd1);

      // clear and NACK to the same flow in one cycle: slot emptied, NACK dropped
      send(3, 300, 0, 1024);
      in_valid     = 1'b1;
      in_pkt_type  = NACK_PKT;
      in_flow_id   = 2'd3;
      in_seq       = 16'd301;
      in_wnd_start = 16'd0;
      in_wnd_size  = 16'd1024;
      clr_valid    = 1'b1;
      clr_flow_id  = 2'd3;
      step();
      in_valid  = 1'b0;
      clr_valid = 1'b0;
      idle(30);
      check("clr_drop_cnt",  64'(drop_cnt),  64'd2);
      check("clr_no_output", 64'(out_valid), 64'd0);

      // reset mid-stream discards FIFO contents and pending ranges
      out_ready = 1'b0;
      send(0, 400, 0, 1024);
      send(0, 402, 0, 1024);
      send(0, 404, 0, 1024);
      check("pre_reset_out_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready",  64'(in_ready),  64'd1);
      check("midrst_drop_cnt",  64'(drop_cnt),  64'd0);
      check("midrst_out_data",  64'({out_flow_id, out_rtx_start, out_rtx_end}), 64'd0);
      out_ready = 1'b1;
      idle(30);
      check("post_rst_silent", 64'(out_valid), 64'd0);
      check("queue_empty_end", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
